id_hazard_scoreboard: RTL
=========================

ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter AW, default 5, register address width; NREG = 2**AW.
REQ-003 SHALL have parameter WB_LAT, default 3, cycles from ID issue to WB register write; legal range 2..15.
REQ-004 SHALL have parameter SC_W, default 16, width of stall performance counter.
REQ-005 SHALL use one clock and a synchronous, active-high reset, ports named clock and reset.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 issue_valid  input  1  valid instruction present in ID.
REQ-009 rs1, rs2  input  AW each  source register addresses.
REQ-010 rs1_used, rs2_used  input  1 each  source actually read by the instruction.
REQ-011 rd  input  AW  destination register.
REQ-012 rd_write  input  1  instruction writes rd.
REQ-013 is_load  input  1  instruction is a load.
REQ-014 flush  input  1  taken branch; kill instruction in ID.
REQ-015 stall  output  1  hazard stall.
REQ-016 pc_enable, if_id_enable  output  1 each  equal to ~stall.
REQ-017 id_ex_bubble  output  1  insert NOP into ID/EX.
REQ-018 flush_if_id  output  1  clear IF/ID register.
REQ-019 busy_vec  output  NREG  bit i set when counter[i] nonzero.
REQ-020 stall_cycles  output  SC_W  saturating count of stall cycles.

Function
REQ-021 SHALL hold per register a down-counter of width $clog2(WB_LAT+1) and a load flag.
REQ-022 Issue SHALL occur when issue_valid & ~stall & ~flush; on issue with rd_write and rd!=0, counter[rd] SHALL load WB_LAT and flag[rd] SHALL load is_load at the next edge.
REQ-023 Every nonzero counter not being reloaded SHALL decrement by 1 each cycle; a reaching-zero counter SHALL clear its load flag.
REQ-024 Reissue to a pending rd (WAW) SHALL overwrite counter and flag; decrement SHALL NOT apply that cycle.
REQ-025 Register 0 SHALL never be tracked; sources equal to 0 or with *_used low SHALL never cause a hazard.
REQ-026 Source hazard condition SHALL be per REQ-036/REQ-037; stall = issue_valid & ~flush & (hazard on rs1 | hazard on rs2), combinational, same cycle.
REQ-027 id_ex_bubble SHALL equal stall | flush; flush_if_id SHALL equal flush.
REQ-028 Flush and hazard in the same cycle: flush wins, stall=0, no scoreboard update.
REQ-029 stall_cycles SHALL increment by 1 on each edge where stall=1, holding at 2**SC_W-1.
REQ-030 Counter value 1 SHALL denote WB writing this cycle; register file write-through covers it, so counter==1 SHALL NOT stall.

Reset
REQ-031 On reset all counters, load flags and stall_cycles SHALL clear at the next edge.
REQ-032 After reset busy_vec=0, stall=0, pc_enable=1, if_id_enable=1; id_ex_bubble and flush_if_id follow flush.
REQ-033 Reset mid-stall SHALL discard all pending entries; reset SHALL take priority over issue in the same cycle.
REQ-034 No output SHALL be X after the first reset edge.

Configuration
REQ-035 Macro FORWARDING_EN SHALL select hazard policy.
REQ-036 Without FORWARDING_EN: hazard on rsN iff counter[rsN] > 1.
REQ-037 With FORWARDING_EN: hazard on rsN iff flag[rsN] & counter[rsN]==WB_LAT (load-use only; ALU results forwarded).

Verification (WB_LAT=3)
REQ-038 No FORWARDING_EN: issue rd=5 ALU, next cycle rs1=5 -> stall=1 two cycles, issues third cycle, stall_cycles=2.
REQ-039 FORWARDING_EN: lw rd=4 then rs2=4 -> exactly one stall cycle; ALU rd=6 then rs1=6 -> zero stalls.
REQ-040 Producer rd=0 then consumer rs1=0 -> stall=0, busy_vec=0.
REQ-041 Hazard pending plus flush=1 same cycle -> stall=0, id_ex_bubble=1, flush_if_id=1, busy_vec unchanged except decrement.
REQ-042 FORWARDING_EN: load rd=5 then ALU rd=5 back-to-back, then rs1=5 -> no stall (flag overwritten).
REQ-043 reset=1 with busy_vec=0x20 and stall_cycles=3 -> next cycle busy_vec=0, stall=0, stall_cycles=0.

Source files
------------

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus.
// master: ID/decode side. It drives the instruction fields and flush, and it
//         receives the stall/bubble controls, busy_vec and stall_cycles.
// slave : the scoreboard itself.
interface id_hazard_scoreboard_if #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 32,
  parameter int unsigned SC_W = 16
);
  logic            issue_valid;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_used;
  logic            rs2_used;
  logic [AW-1:0]   rd;
  logic            rd_write;
  logic            is_load;
  logic            flush;
  logic            stall;
  logic            pc_enable;
  logic            if_id_enable;
  logic            id_ex_bubble;
  logic            flush_if_id;
  logic [NREG-1:0] busy_vec;
  logic [SC_W-1:0] stall_cycles;

  modport master (
    output issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, is_load, flush,
    input  stall, pc_enable, if_id_enable, id_ex_bubble, flush_if_id, busy_vec, stall_cycles
  );

  modport slave (
    input  issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_write, is_load, flush,
    output stall, pc_enable, if_id_enable, id_ex_bubble, flush_if_id, busy_vec, stall_cycles
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ID-stage register hazard scoreboard.
// Each register has a down-counter that is loaded with WB_LAT when an
// instruction writing that register issues, and a flag marking the producer
// as a load. The block stalls ID while a source register is still in flight.
// Ports: clock and reset (synchronous, active-high), plus sb
//        (id_hazard_scoreboard_if.slave), which carries the issue fields in and
//        stall/pc_enable/if_id_enable/id_ex_bubble/flush_if_id/busy_vec/
//        stall_cycles out.
// Config: define FORWARDING_EN to stall only on load-use. In the default build
//         the block stalls on any pending producer whose count is above 1.
module id_hazard_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned SC_W   = 16
) (
  input logic                  clock,
  input logic                  reset,
  id_hazard_scoreboard_if.slave sb
);
  localparam int unsigned CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(WB_LAT);

  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [NREG-1:0] flag_q, flag_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            haz1, haz2, stall, do_write;

  // Source hazard detection. Register 0 and unused sources never hazard.
  always_comb begin
`ifdef FORWARDING_EN
    // ALU results are forwarded; only a load issued last cycle is too late.
    haz1 = sb.rs1_used && (sb.rs1 != '0) && flag_q[sb.rs1] && (cnt_q[sb.rs1] == LAT);
    haz2 = sb.rs2_used && (sb.rs2 != '0) && flag_q[sb.rs2] && (cnt_q[sb.rs2] == LAT);
`else
    // A count of 1 means WB writes this cycle and the register file writes through.
    haz1 = sb.rs1_used && (sb.rs1 != '0) && (cnt_q[sb.rs1] > CW'(1));
    haz2 = sb.rs2_used && (sb.rs2 != '0) && (cnt_q[sb.rs2] > CW'(1));
`endif
    stall    = sb.issue_valid && !sb.flush && (haz1 || haz2);
    do_write = sb.issue_valid && !stall && !sb.flush && sb.rd_write && (sb.rd != '0);
  end

  // Next-state logic. A reload (WAW) takes precedence over the decrement.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i]  = cnt_q[i];
      flag_d[i] = flag_q[i];
      if (i == 0) begin
        cnt_d[i]  = '0;
        flag_d[i] = 1'b0;
      end else if (do_write && (sb.rd == AW'(i))) begin
        cnt_d[i]  = LAT;
        flag_d[i] = sb.is_load;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
        if (cnt_q[i] == CW'(1)) flag_d[i] = 1'b0;
      end
    end
    sc_d = sc_q;
    if (stall && (sc_q != '1)) sc_d = sc_q + SC_W'(1);
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
      flag_q <= '0;
      sc_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      flag_q <= flag_d;
      sc_q   <= sc_d;
    end
  end

  // Outputs. The stall controls are combinational so they act in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) sb.busy_vec[i] = (cnt_q[i] != '0);
  end

  assign sb.stall        = stall;
  assign sb.pc_enable    = !stall;
  assign sb.if_id_enable = !stall;
  assign sb.id_ex_bubble = stall || sb.flush;
  assign sb.flush_if_id  = sb.flush;
  assign sb.stall_cycles = sc_q;
endmodule
